// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/MDU execute-stage block.
//   - ALU_* : 4-bit opcode encodings presented on alu_op
//   - state_e : control FSM states (idle, multiply, divide, done)
//   - is_mdu() : true for the iterative multiply/divide opcodes
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_MULTU = 4'b1101;
  localparam logic [3:0] ALU_DIVU  = 4'b1110;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } state_e;

  function automatic logic is_mdu(input logic [3:0] op);
    return (op == ALU_MULTU) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/result handshake bundle for alu_mdu.
//   Request side : in_valid, in_ready, a, b, alu_op
//   Result side  : out_valid, out_ready, result, hi, zero, overflow, illegal
// slave  : the alu_mdu block itself
// master : the control unit / testbench driving requests and consuming results
interface alu_mdu_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport slave (
    input  in_valid, a, b, alu_op, out_ready,
    output in_ready, out_valid, result, hi, zero, overflow, illegal
  );

  modport master (
    output in_valid, a, b, alu_op, out_ready,
    input  in_ready, out_valid, result, hi, zero, overflow, illegal
  );

endinterface

// File: rtl/alu_mdu_iter.sv
// Iterative unsigned multiply / restoring divide datapath, one bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : pulse; captures a_i/b_i and the operation (div_i) this edge
//   div_i      : 1 = divide a_i/b_i, 0 = multiply a_i*b_i
//   done_o     : high during the final iteration cycle
//   lo_o, hi_o : value the LO/HI pair takes at the end of the current
//                iteration; final product or quotient/remainder when done_o
// Multiply: acc:lo holds the running product, lo starts as the multiplier.
// Divide:   acc is the partial remainder, lo shifts the dividend out and the
//           quotient in. A zero divisor naturally yields all-ones / dividend.
module alu_mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  logic             busy_q;
  logic             div_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   shifted;
  logic             fits;

  always_comb begin
    mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {acc_q, lo_q[WIDTH-1]};
    fits    = shifted >= {1'b0, opnd_q};
    if (div_q) begin
      // Restoring step: keep the subtraction only when it does not go negative.
      acc_d = fits ? WIDTH'(shifted - {1'b0, opnd_q}) : shifted[WIDTH-1:0];
      lo_d  = {lo_q[WIDTH-2:0], fits};
    end else begin
      // Shift-add step: add multiplicand on a set multiplier bit, shift pair right.
      acc_d = mul_sum[WIDTH:1];
      lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign done_o = busy_q && (cnt_q == CntW'(WIDTH - 1));
  assign lo_o   = lo_d;
  assign hi_o   = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      div_q  <= div_i;
      cnt_q  <= '0;
      acc_q  <= '0;
      lo_q   <= div_i ? a_i : b_i;
      opnd_q <= div_i ? b_i : a_i;
    end else if (busy_q) begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CntW'(1);
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Registered ALU plus iterative unsigned multiply/divide for the EX stage.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_mdu_if.slave -- request (in_valid/in_ready, a, b, alu_op) and
//           result (out_valid/out_ready, result, hi, zero, overflow, illegal)
// ALU ops produce a result the cycle after accept; MULTU/DIVU run WIDTH
// iterations in alu_mdu_iter and present {hi,result} WIDTH+1 cycles after
// accept. One operation in flight at a time, results in order.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst_n,
  alu_mdu_if.slave bus
);

  state_e state_q, state_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;

  logic             in_ready;
  logic             accept;
  logic             start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               alu_ill;
  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   sum;
  logic [SHAMT_W-1:0] shamt;

  // Back-to-back accepts are allowed when the held result is popped this cycle.
  assign in_ready = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Combinational ALU on the live request; its value is registered on accept.
  always_comb begin
    b_eff   = (bus.alu_op == ALU_SUB) ? (~bus.b + WIDTH'(1)) : bus.b;
    sum     = bus.a + b_eff;
    shamt   = bus.b[SHAMT_W-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (bus.alu_op)
      ALU_AND: alu_res = bus.a & bus.b;
      ALU_OR:  alu_res = bus.a | bus.b;
      ALU_XOR: alu_res = bus.a ^ bus.b;
      ALU_NOR: alu_res = ~(bus.a | bus.b);
      ALU_ADD, ALU_SUB: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      ALU_SLL: alu_res = bus.a << shamt;
      ALU_SRL: alu_res = bus.a >> shamt;
      ALU_SRA: alu_res = $signed(bus.a) >>> shamt;
      ALU_MULTU, ALU_DIVU: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  alu_mdu_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start),
    .div_i  (bus.alu_op == ALU_DIVU),
    .a_i    (bus.a),
    .b_i    (bus.b),
    .done_o (iter_done),
    .lo_o   (iter_lo),
    .hi_o   (iter_hi)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    hi_d        = hi_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    illegal_d   = illegal_q;
    start       = 1'b0;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mdu(bus.alu_op)) begin
            start   = 1'b1;
            state_d = (bus.alu_op == ALU_DIVU) ? StDiv : StMul;
          end else begin
            result_d    = alu_res;
            hi_d        = '0;
            zero_d      = (alu_res == '0);
            overflow_d  = alu_ovf;
            illegal_d   = alu_ill;
            out_valid_d = 1'b1;
          end
        end
      end
      StMul, StDiv: begin
        // Load on the last iteration so the result appears WIDTH+1 cycles after accept.
        if (iter_done) begin
          result_d    = iter_lo;
          hi_d        = iter_hi;
          zero_d      = (iter_lo == '0);
          overflow_d  = 1'b0;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.hi        = hi_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed corner cases, hold/back-to-back
// handshakes, reset mid-multiply and randomized ops against a reference model.
module tb_alu_mdu;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mdu_if #(.WIDTH(W)) bus ();

  alu_mdu #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         ovf;
    logic         ill;
    int           lat;
  } exp_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference behaviour from plain arithmetic on the operands.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t         e;
    longint       exact;
    logic [63:0]  prod;
    logic [W-1:0] bneg;
    int           sh;
    sh    = int'(b % W);
    e.res = '0;
    e.hi  = '0;
    e.ovf = 1'b0;
    e.ill = 1'b0;
    e.lat = 1;
    case (op)
      ALU_AND: e.res = a & b;
      ALU_OR:  e.res = a | b;
      ALU_XOR: e.res = a ^ b;
      ALU_NOR: e.res = ~(a | b);
      ALU_ADD: begin
        e.res = a + b;
        exact = longint'($signed(a)) + longint'($signed(b));
        e.ovf = (exact != longint'($signed(e.res)));
      end
      ALU_SUB: begin
        bneg  = -b;
        e.res = a - b;
        exact = longint'($signed(a)) + longint'($signed(bneg));
        e.ovf = (exact != longint'($signed(e.res)));
      end
      ALU_SLT: e.res = (longint'($signed(a)) < longint'($signed(b))) ? 1 : 0;
      ALU_SLL: e.res = a << sh;
      ALU_SRL: e.res = a >> sh;
      ALU_SRA: e.res = W'(longint'($signed(a)) >>> sh);
      ALU_MULTU: begin
        prod  = 64'(a) * 64'(b);
        e.res = prod[W-1:0];
        e.hi  = prod[63:W];
        e.lat = W + 1;
      end
      ALU_DIVU: begin
        if (b == 0) begin
          e.res = '1;
          e.hi  = a;
        end else begin
          e.res = a / b;
          e.hi  = a % b;
        end
        e.lat = W + 1;
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  // One op, entered #1 after a rising edge with no result pending.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    int           lat;
    bit           rdy_seen;
    logic [W-1:0] held;
    e = model(op, a, b);
    bus.alu_op    = op;
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    lat = 0;
    while (!bus.in_ready && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 100) check("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;  // must be ignored after capture
    bus.b        = $urandom;
    bus.alu_op   = 4'($urandom);
    lat      = 1;
    rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(e.lat));
    if (e.lat > 1) check("in_ready_busy", {63'd0, rdy_seen}, 64'd0);
    check("result", 64'(bus.result), 64'(e.res));
    check("hi", 64'(bus.hi), 64'(e.hi));
    check("zero", {63'd0, bus.zero}, {63'd0, e.zero});
    check("overflow", {63'd0, bus.overflow}, {63'd0, e.ovf});
    check("illegal", {63'd0, bus.illegal}, {63'd0, e.ill});
    check("in_ready_pending", {63'd0, bus.in_ready}, 64'd0);
    held          = bus.result;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("pop_valid", {63'd0, bus.out_valid}, 64'd0);
    check("pop_hold", 64'(bus.result), 64'(held));
  endtask

  logic [3:0] legal [12] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SUB, ALU_SLT,
                             ALU_SLL, ALU_SRL, ALU_SRA, ALU_NOR, ALU_MULTU, ALU_DIVU};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t         e;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    bit           seen;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.alu_op    = '0;

    #12;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_flags", {61'd0, bus.zero, bus.overflow, bus.illegal}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed corner cases
    do_op(ALU_ADD, 32'd7, 32'd5);
    do_op(ALU_SUB, 32'd5, 32'd5);
    do_op(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    do_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    do_op(ALU_SRA, 32'h8000_0000, 32'd4);
    do_op(ALU_SRL, 32'h8000_0000, 32'd4);
    do_op(4'b0100, 32'h1234_5678, 32'h9ABC_DEF0);
    do_op(ALU_MULTU, 32'hFFFF_FFFF, 32'd2);
    do_op(ALU_DIVU, 32'd100, 32'd7);
    do_op(ALU_DIVU, 32'd9, 32'd0);
    do_op(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Result held under back-pressure; new request must not be taken
    bus.alu_op   = ALU_ADD;
    bus.a        = 32'd3;
    bus.b        = 32'd4;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.alu_op = ALU_SUB;
    bus.a      = 32'd9;
    bus.b      = 32'd1;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {63'd0, bus.out_valid}, 64'd1);
      check("hold_result", 64'(bus.result), 64'd7);
      check("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    // Pop and accept in the same cycle
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("popacc_valid", {63'd0, bus.out_valid}, 64'd1);
    check("popacc_result", 64'(bus.result), 64'd8);
    @(posedge clk);
    #1;
    check("drain_valid", {63'd0, bus.out_valid}, 64'd0);
    check("drain_hold", 64'(bus.result), 64'd8);

    // Back-to-back ALU stream, one result per cycle
    for (int i = 0; i < 20; i++) begin
      op = legal[$urandom_range(0, 9)];
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      e  = model(op, a, b);
      bus.alu_op   = op;
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = 1'b1;
      check("stream_in_ready", {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk);
      #1;
      check("stream_valid", {63'd0, bus.out_valid}, 64'd1);
      check("stream_result", 64'(bus.result), 64'(e.res));
      check("stream_flags", {61'd0, bus.zero, bus.overflow, bus.illegal},
            {61'd0, e.zero, e.ovf, e.ill});
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("stream_end_valid", {63'd0, bus.out_valid}, 64'd0);

    // Reset during a multiply abandons it
    do_op(ALU_ADD, 32'd7, 32'd5);
    bus.alu_op   = ALU_MULTU;
    bus.a        = 32'h0001_0003;
    bus.b        = 32'h0000_0101;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("midrst_result", 64'(bus.result), 64'd0);
    check("midrst_hi", 64'(bus.hi), 64'd0);
    check("midrst_flags", {61'd0, bus.zero, bus.overflow, bus.illegal}, 64'd0);
    check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("midrst_abandoned", {63'd0, seen}, 64'd0);
    do_op(ALU_ADD, 32'd7, 32'd5);

    // Randomized mix including illegal opcodes and small divisors
    for (int i = 0; i < 150; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : legal[$urandom_range(0, 11)];
      a  = ($urandom_range(0, 4) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
      b  = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      do_op(op, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
